// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction fields into 16-bit words and streams them
// through a small FIFO into a sequential instruction-memory write port.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
module instr_encoder #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  finish,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_itype,
  input  logic [3:0]            in_opcode,
  input  logic [3:0]            in_dest,
  input  logic [3:0]            in_src1,
  input  logic [3:0]            in_src2,
  input  logic [7:0]            in_imm,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t                state_q;
  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PW:0]           wr_q, rd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  wrap_q;
  logic [DATA_WIDTH-1:0] enc_d;
  logic                  empty, full, push, pop, active;
  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = wr_q == rd_q;
  assign full      = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign active    = (state_q == RUN) || (state_q == DRAIN);
  assign in_ready  = (state_q == RUN) && !full;
  assign push      = in_valid && in_ready;
  assign mem_we    = active && !empty;
  assign pop       = mem_we && mem_ready;
  assign enc_d     = in_itype ? {in_opcode, in_dest, in_imm} : {in_opcode, in_dest, in_src1, in_src2};
  assign mem_wdata = mem_we ? fifo_q[rd_q[PW-1:0]] : '0;
  assign mem_addr  = addr_q;
  assign count     = count_q;
  assign busy      = active;
  assign done      = state_q == DONE;
  assign wrap_err  = wrap_q;
  always_ff @(posedge clk)
    if (push) fifo_q[wr_q[PW-1:0]] <= enc_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) begin
        rd_q    <= rd_q + 1'b1;
        addr_q  <= addr_q + 1'b1;
        count_q <= count_q + 1'b1;
        if (&addr_q) wrap_q <= 1'b1;
      end
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          addr_q  <= base_addr;
          count_q <= '0;
          wrap_q  <= 1'b0;
          wr_q    <= '0;
          rd_q    <= '0;
        end
        RUN:     if (finish) state_q <= DRAIN;
        DRAIN:   if (empty) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scenario tests for instr_encoder with hand-computed expectations.
module tb_instr_encoder;
  logic        clk = 0, rst_n = 0, start = 0, finish = 0, in_valid = 0, in_itype = 0, mem_ready = 0;
  logic [7:0]  base_addr = 0, in_imm = 0;
  logic [3:0]  in_opcode = 0, in_dest = 0, in_src1 = 0, in_src2 = 0;
  logic        in_ready, mem_we, busy, done, wrap_err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [8:0]  count;
  int          pass_cnt = 0, total_cnt = 0;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_itype(in_itype), .in_opcode(in_opcode),
    .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .busy(busy), .done(done), .wrap_err(wrap_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_r(input logic [3:0] op, d, s1, s2);
    in_itype = 0; in_opcode = op; in_dest = d; in_src1 = s1; in_src2 = s2;
  endtask

  task automatic set_i(input logic [3:0] op, d, input logic [7:0] imm);
    in_itype = 1; in_opcode = op; in_dest = d; in_imm = imm;
  endtask

  task automatic begin_session(input logic [7:0] a);
    base_addr = a; start = 1;
    tick;
    start = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    #2;
    total_cnt++; if ({mem_we, in_ready, busy, done, wrap_err} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {mem_we, in_ready, busy, done, wrap_err}); else pass_cnt++;
    total_cnt++; if ({mem_addr, mem_wdata, count} !== 33'b0) $display("FAIL reset_values got addr=%h data=%h count=%0d want 0", mem_addr, mem_wdata, count); else pass_cnt++;
    tick;
    rst_n = 1;
    tick;
    finish = 1;
    tick;
    finish = 0;
    total_cnt++; if (busy !== 0 || done !== 0) $display("FAIL finish_in_idle got busy=%b done=%b want 0 0", busy, done); else pass_cnt++;
  endtask

  task automatic test_rtype;
    mem_ready = 1;
    begin_session(8'h10);
    total_cnt++; if (in_ready !== 1 || busy !== 1) $display("FAIL run_ready got in_ready=%b busy=%b want 1 1", in_ready, busy); else pass_cnt++;
    set_r(4'h3, 4'h1, 4'h2, 4'h4); in_valid = 1;
    tick;
    in_valid = 0;
    total_cnt++; if (mem_we !== 1 || mem_addr !== 8'h10 || mem_wdata !== 16'h3124) $display("FAIL rtype_write got we=%b addr=%h data=%h want 1 10 3124", mem_we, mem_addr, mem_wdata); else pass_cnt++;
    tick;
    total_cnt++; if (count !== 9'd1 || mem_we !== 0) $display("FAIL rtype_count got count=%0d we=%b want 1 0", count, mem_we); else pass_cnt++;
  endtask

  task automatic test_itype;
    set_i(4'hA, 4'h5, 8'h7F); in_valid = 1;
    tick;
    in_valid = 0;
    total_cnt++; if (mem_we !== 1 || mem_addr !== 8'h11 || mem_wdata !== 16'hA57F) $display("FAIL itype_write got we=%b addr=%h data=%h want 1 11 a57f", mem_we, mem_addr, mem_wdata); else pass_cnt++;
    tick;
    finish = 1;
    tick;
    finish = 0;
    total_cnt++; if (busy !== 1 || done !== 0 || in_ready !== 0) $display("FAIL drain_state got busy=%b done=%b rdy=%b want 1 0 0", busy, done, in_ready); else pass_cnt++;
    tick;
    total_cnt++; if (done !== 1 || busy !== 0) $display("FAIL done_pulse got done=%b busy=%b want 1 0", done, busy); else pass_cnt++;
    tick;
    total_cnt++; if (done !== 0 || busy !== 0 || count !== 9'd2) $display("FAIL idle_hold got done=%b busy=%b count=%0d want 0 0 2", done, busy, count); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic [15:0] exp_w [5];
    logic        acc;
    exp_w[0] = 16'h1023; exp_w[1] = 16'h2123; exp_w[2] = 16'h3223; exp_w[3] = 16'h4323; exp_w[4] = 16'h5423;
    mem_ready = 0;
    begin_session(8'h20);
    for (int i = 0; i < 4; i++) begin
      set_r(4'(i + 1), 4'(i), 4'h2, 4'h3); in_valid = 1;
      tick;
    end
    set_r(4'h5, 4'h4, 4'h2, 4'h3);
    total_cnt++; if (in_ready !== 0) $display("FAIL full_ready got %b want 0", in_ready); else pass_cnt++;
    tick;
    total_cnt++; if (mem_we !== 1 || mem_addr !== 8'h20 || mem_wdata !== 16'h1023) $display("FAIL stall_stable got we=%b addr=%h data=%h want 1 20 1023", mem_we, mem_addr, mem_wdata); else pass_cnt++;
    mem_ready = 1;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (mem_we !== 1 || mem_addr !== 8'(8'h20 + i) || mem_wdata !== exp_w[i]) $display("FAIL bp_write%0d got we=%b addr=%h data=%h want 1 %h %h", i, mem_we, mem_addr, mem_wdata, 8'(8'h20 + i), exp_w[i]); else pass_cnt++;
      acc = in_valid && in_ready;
      tick;
      if (acc) in_valid = 0;
    end
    total_cnt++; if (mem_we !== 0 || count !== 9'd5 || in_valid !== 0) $display("FAIL bp_end got we=%b count=%0d pending=%b want 0 5 0", mem_we, count, in_valid); else pass_cnt++;
    finish = 1;
    tick;
    finish = 0;
    tick;
    tick;
  endtask

  task automatic test_wrap;
    mem_ready = 0;
    begin_session(8'hFE);
    for (int i = 0; i < 3; i++) begin
      set_i(4'hC, 4'h2, 8'(i)); in_valid = 1;
      tick;
    end
    in_valid = 0;
    mem_ready = 1;
    total_cnt++; if (mem_addr !== 8'hFE || mem_wdata !== 16'hC200 || wrap_err !== 0) $display("FAIL wrap_w0 got addr=%h data=%h err=%b want fe c200 0", mem_addr, mem_wdata, wrap_err); else pass_cnt++;
    tick;
    total_cnt++; if (mem_addr !== 8'hFF || mem_wdata !== 16'hC201 || wrap_err !== 0) $display("FAIL wrap_w1 got addr=%h data=%h err=%b want ff c201 0", mem_addr, mem_wdata, wrap_err); else pass_cnt++;
    tick;
    total_cnt++; if (mem_we !== 1 || mem_addr !== 8'h00 || mem_wdata !== 16'hC202) $display("FAIL wrap_w2 got we=%b addr=%h data=%h want 1 00 c202", mem_we, mem_addr, mem_wdata); else pass_cnt++;
    tick;
    total_cnt++; if (wrap_err !== 1 || mem_addr !== 8'h01 || count !== 9'd3) $display("FAIL wrap_err got err=%b addr=%h count=%0d want 1 01 3", wrap_err, mem_addr, count); else pass_cnt++;
    finish = 1;
    tick;
    finish = 0;
    tick;
    tick;
    begin_session(8'h00);
    total_cnt++; if (wrap_err !== 0) $display("FAIL wrap_clear got %b want 0", wrap_err); else pass_cnt++;
    finish = 1;
    tick;
    finish = 0;
    tick;
    tick;
  endtask

  task automatic test_reset_mid;
    int stray;
    mem_ready = 0;
    begin_session(8'h40);
    for (int i = 0; i < 4; i++) begin
      set_r(4'h7, 4'(i), 4'h0, 4'h0); in_valid = 1;
      tick;
    end
    in_valid = 0;
    mem_ready = 1;
    tick;
    mem_ready = 0;
    total_cnt++; if (count !== 9'd1 || mem_we !== 1 || mem_addr !== 8'h41) $display("FAIL pre_reset got count=%0d we=%b addr=%h want 1 1 41", count, mem_we, mem_addr); else pass_cnt++;
    #2;
    rst_n = 0;
    #1;
    total_cnt++; if (mem_we !== 0 || busy !== 0 || count !== 9'd0 || in_ready !== 0) $display("FAIL async_reset got we=%b busy=%b count=%0d rdy=%b want 0 0 0 0", mem_we, busy, count, in_ready); else pass_cnt++;
    tick;
    rst_n = 1;
    mem_ready = 1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (mem_we !== 0) stray++;
    end
    total_cnt++; if (stray !== 0) $display("FAIL post_reset_writes got %0d want 0", stray); else pass_cnt++;
  endtask

  task automatic test_stray_start;
    mem_ready = 1;
    begin_session(8'h80);
    base_addr = 8'h33; start = 1;
    tick;
    start = 0;
    total_cnt++; if (mem_addr !== 8'h80 || busy !== 1) $display("FAIL stray_start got addr=%h busy=%b want 80 1", mem_addr, busy); else pass_cnt++;
    finish = 1;
    tick;
    finish = 0;
    total_cnt++; if (done !== 0 || busy !== 1) $display("FAIL empty_drain got done=%b busy=%b want 0 1", done, busy); else pass_cnt++;
    tick;
    total_cnt++; if (done !== 1 || mem_addr !== 8'h80 || count !== 9'd0) $display("FAIL empty_done got done=%b addr=%h count=%0d want 1 80 0", done, mem_addr, count); else pass_cnt++;
    tick;
  endtask

  task automatic test_back_to_back;
    mem_ready = 1;
    begin_session(8'h50);
    set_i(4'h9, 4'h8, 8'h12); in_valid = 1; finish = 1;
    tick;
    in_valid = 0; finish = 0;
    total_cnt++; if (mem_we !== 1 || mem_wdata !== 16'h9812 || in_ready !== 0 || busy !== 1) $display("FAIL finish_push got we=%b data=%h rdy=%b busy=%b want 1 9812 0 1", mem_we, mem_wdata, in_ready, busy); else pass_cnt++;
    tick;
    total_cnt++; if (count !== 9'd1 || done !== 0) $display("FAIL finish_push_pop got count=%0d done=%b want 1 0", count, done); else pass_cnt++;
    tick;
    total_cnt++; if (done !== 1) $display("FAIL finish_push_done got %b want 1", done); else pass_cnt++;
    tick;
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_itype;
    test_backpressure;
    test_wrap;
    test_reset_mid;
    test_stray_start;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
